// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-address sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int HOLD_CNT_W = 4;

    // Number of PC low bits that must be zero for an aligned fetch.
    function automatic int pc_align_bits(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

endpackage

// File: rtl/pc_hold_timer.sv
// Post-reset hold counter: done rises on the last HOLD cycle so the FSM leaves HOLD next edge.
module pc_hold_timer
    import pc_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic done
);

    localparam logic [HOLD_CNT_W-1:0] LAST_CNT =
        HOLD_CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    logic [HOLD_CNT_W-1:0] cnt_q;
    logic [HOLD_CNT_W-1:0] cnt_d;

    assign done = (HOLD_CYCLES == 0) || (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (en && !done) begin
            cnt_d = cnt_q + HOLD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: reset hold, valid/ready fetch stream, trap/redirect with epoch tagging, halt/resume.
// Build option PC_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being truncated.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RESET_HOLD   = 1,
    parameter int              EPOCH_W      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_ready,
    output logic               fetch_valid,
    output logic [XLEN-1:0]    fetch_pc,
    output logic [EPOCH_W-1:0] fetch_epoch,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_vector,
    input  logic               halt_req,
    input  logic               resume,
    output logic               halted,
    output logic               misalign
);

    localparam int              PC_ALIGN_BITS = pc_align_bits(INSTR_BYTES);
    localparam logic [XLEN-1:0] LOW_MASK      = XLEN'((1 << PC_ALIGN_BITS) - 1);
    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(INSTR_BYTES);

    pc_state_t          state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               misalign_q, misalign_d;
    logic               hold_done;
    logic               redir_bad;
    logic [XLEN-1:0]    redir_target;

    pc_hold_timer #(
        .HOLD_CYCLES(RESET_HOLD)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .en   (state_q == HOLD),
        .done (hold_done)
    );

`ifdef PC_MISALIGN_TRAP_EN
    assign redir_bad    = |(redirect_pc & LOW_MASK);
    assign redir_target = redirect_pc;
`else
    // Without the trap option the target is silently aligned down.
    assign redir_bad    = 1'b0;
    assign redir_target = redirect_pc & ~LOW_MASK;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        misalign_d = 1'b0;
        case (state_q)
            HOLD: begin
                if (hold_done) begin
                    state_d = RUN;
                end
            end
            RUN, HALT: begin
                if (trap_valid) begin
                    pc_d    = trap_vector;
                    epoch_d = epoch_q + EPOCH_W'(1);
                end else if (redirect_valid) begin
                    epoch_d = epoch_q + EPOCH_W'(1);
                    if (redir_bad) begin
                        pc_d       = trap_vector;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = redir_target;
                    end
                end else if (state_q == RUN && fetch_ready) begin
                    pc_d = pc_q + PC_STEP;
                end
                // Resume wins over a simultaneous halt request while halted.
                if (state_q == RUN && halt_req) begin
                    state_d = HALT;
                end else if (state_q == HALT && resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HOLD;
            pc_q       <= RESET_VECTOR;
            epoch_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            misalign_q <= misalign_d;
        end
    end

    assign fetch_valid = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign fetch_pc    = pc_q;
    assign fetch_epoch = epoch_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench: a default-hold instance and a RESET_HOLD=3 instance share stimulus.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;

    logic        a_valid, a_halted, a_mis;
    logic [31:0] a_pc;
    logic [1:0]  a_ep;
    logic        b_valid, b_halted, b_mis;
    logic [31:0] b_pc;
    logic [1:0]  b_ep;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          sel;
        string       tag;
        logic        v;
        logic [31:0] pc;
        logic [1:0]  ep;
        logic        h;
        logic        m;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer dut_a (
        .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
        .fetch_valid(a_valid), .fetch_pc(a_pc), .fetch_epoch(a_ep),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .halt_req(halt_req), .resume(resume),
        .halted(a_halted), .misalign(a_mis)
    );

    pc_sequencer #(.RESET_HOLD(3)) dut_b (
        .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
        .fetch_valid(b_valid), .fetch_pc(b_pc), .fetch_epoch(b_ep),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .halt_req(halt_req), .resume(resume),
        .halted(b_halted), .misalign(b_mis)
    );

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input string tag, input logic v, input logic [31:0] pc,
                        input logic [1:0] ep, input logic h, input logic m);
        exp_t e;
        e.sel = sel; e.tag = tag; e.v = v; e.pc = pc; e.ep = ep; e.h = h; e.m = m;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 1'b0) begin
                cmp(e.tag, "valid", 32'(a_valid), 32'(e.v));
                cmp(e.tag, "pc", a_pc, e.pc);
                cmp(e.tag, "epoch", 32'(a_ep), 32'(e.ep));
                cmp(e.tag, "halted", 32'(a_halted), 32'(e.h));
                cmp(e.tag, "misalign", 32'(a_mis), 32'(e.m));
            end else begin
                cmp(e.tag, "valid", 32'(b_valid), 32'(e.v));
                cmp(e.tag, "pc", b_pc, e.pc);
                cmp(e.tag, "epoch", 32'(b_ep), 32'(e.ep));
                cmp(e.tag, "halted", 32'(b_halted), 32'(e.h));
                cmp(e.tag, "misalign", 32'(b_mis), 32'(e.m));
            end
            $display("check %-10s inst=%0d pc=%h valid=%0b epoch=%0d halted=%0b misalign=%0b",
                     e.tag, e.sel, e.pc, e.v, e.ep, e.h, e.m);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        // Reset held for two edges.
        push(0, "rst0", 0, 32'h0, 0, 0, 0); tick();
        push(0, "rst1", 0, 32'h0, 0, 0, 0); push(1, "rst1b", 0, 32'h0, 0, 0, 0); tick();

        reset = 1'b0;
        push(0, "cyc1", 0, 32'h0, 0, 0, 0); drain();
        push(0, "cyc2", 1, 32'h0, 0, 0, 0); tick();
        push(0, "seq4", 1, 32'h4, 0, 0, 0); tick();
        push(0, "seq8", 1, 32'h8, 0, 0, 0); tick();
        push(0, "seq12", 1, 32'hC, 0, 0, 0); tick();
        push(0, "seq16", 1, 32'h10, 0, 0, 0); tick();

        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(0, "stall", 1, 32'h10, 0, 0, 0); tick();
        end
        fetch_ready = 1'b1;
        push(0, "unstall", 1, 32'h14, 0, 0, 0); tick();

        redirect_valid = 1'b1; redirect_pc = 32'h100;
        push(0, "redir1", 1, 32'h100, 1, 0, 0); tick();
        redirect_pc = 32'h200;
        push(0, "redir2", 1, 32'h200, 2, 0, 0); tick();
        fetch_ready = 1'b0; redirect_pc = 32'h300;
        push(0, "redir3", 1, 32'h300, 3, 0, 0); tick();
        trap_valid = 1'b1; trap_vector = 32'h80; redirect_pc = 32'h200;
        push(0, "trap_pri", 1, 32'h80, 0, 0, 0); tick();
        trap_valid = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b1;
        push(0, "post_trap", 1, 32'h84, 0, 0, 0); tick();

        redirect_valid = 1'b1; redirect_pc = 32'h102;
`ifdef PC_MISALIGN_TRAP_EN
        push(0, "mis_redir", 1, 32'h80, 1, 0, 1); tick();
        redirect_valid = 1'b0;
        push(0, "mis_after", 1, 32'h84, 1, 0, 0); tick();
`else
        push(0, "mis_redir", 1, 32'h100, 1, 0, 0); tick();
        redirect_valid = 1'b0;
        push(0, "mis_after", 1, 32'h104, 1, 0, 0); tick();
`endif
        redirect_valid = 1'b1; trap_valid = 1'b1;
        push(0, "trap_mis", 1, 32'h80, 2, 0, 0); tick();
        trap_valid = 1'b0; redirect_pc = 32'h40;
        push(0, "to_40", 1, 32'h40, 3, 0, 0); tick();

        redirect_valid = 1'b0; halt_req = 1'b1;
        push(0, "halt_hs", 0, 32'h44, 3, 1, 0); tick();
        halt_req = 1'b0;
        push(0, "halt_idle", 0, 32'h44, 3, 1, 0); tick();
        resume = 1'b1; halt_req = 1'b1;
        push(0, "resume", 1, 32'h44, 3, 0, 0); tick();
        resume = 1'b0; halt_req = 1'b0;
        push(0, "run48", 1, 32'h48, 3, 0, 0); tick();
        halt_req = 1'b1; fetch_ready = 1'b0;
        push(0, "halt2", 0, 32'h48, 3, 1, 0); tick();
        halt_req = 1'b0; trap_valid = 1'b1;
        push(0, "halt_trap", 0, 32'h80, 0, 1, 0); tick();
        trap_valid = 1'b0; resume = 1'b1;
        push(0, "resume2", 1, 32'h80, 0, 0, 0); tick();
        resume = 1'b0; fetch_ready = 1'b1;

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        push(0, "to_top", 1, 32'hFFFF_FFFC, 1, 0, 0); tick();
        redirect_valid = 1'b0;
        push(0, "wrap", 1, 32'h0, 1, 0, 0); tick();

        redirect_valid = 1'b1; redirect_pc = 32'h1000;
        push(0, "to_1000", 1, 32'h1000, 2, 0, 0); tick();
        redirect_valid = 1'b0; fetch_ready = 1'b0;

        // Reset mid-handshake with a trap pending: reset must dominate.
        reset = 1'b1; trap_valid = 1'b1;
        push(0, "rst_mid", 0, 32'h0, 0, 0, 0); push(1, "rst_mid_b", 0, 32'h0, 0, 0, 0); tick();
        reset = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b1; halt_req = 1'b1;
        redirect_pc = 32'h500;
        push(1, "h3_c1", 0, 32'h0, 0, 0, 0); drain();
        push(0, "hold_ign", 1, 32'h0, 0, 0, 0); push(1, "h3_c2", 0, 32'h0, 0, 0, 0); tick();
        trap_valid = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;
        push(0, "rel_seq4", 1, 32'h4, 0, 0, 0); push(1, "h3_c3", 0, 32'h0, 0, 0, 0); tick();
        push(1, "h3_run", 1, 32'h0, 0, 0, 0); tick();
        push(1, "h3_seq4", 1, 32'h4, 0, 0, 0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised fetch-address generator for the pipelined CPU; successor to the single-cycle program counter.
- Holds the PC after reset for a configurable number of cycles, then issues fetch addresses over a valid/ready handshake to the instruction memory stage.
- Applies trap and branch/jump redirects, supports halt/resume, and tags each fetch with a wrap-around epoch so downstream stages can discard wrong-path instructions.

Parameters:
- XLEN, 32, PC width in bits.
- INSTR_BYTES, 4, sequential increment; power of two, 2 or 4.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- RESET_HOLD, 1, cycles after reset deassertion with fetch_valid=0; range 0..15.
- EPOCH_W, 2, epoch tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- fetch_ready  in  1  imem stage accepts the current fetch_pc.
- fetch_valid  out  1  fetch_pc is a valid request.
- fetch_pc  out  XLEN  current fetch address.
- fetch_epoch  out  EPOCH_W  epoch tag of fetch_pc.
- redirect_valid  in  1  branch/jump resolved taken.
- redirect_pc  in  XLEN  redirect target.
- trap_valid  in  1  exception/interrupt taken.
- trap_vector  in  XLEN  trap handler address (mtvec).
- halt_req  in  1  stop fetching (e.g. ecall exit, debug).
- resume  in  1  leave HALT.
- halted  out  1  high while in HALT.
- misalign  out  1  one-cycle pulse on a misaligned redirect (feature only; tied 0 otherwise).

Behaviour:
- reset is synchronous, active-high, and dominates all other inputs, including mid-handshake.
- Reset values: fetch_pc=RESET_VECTOR, fetch_valid=0, fetch_epoch=0, halted=0, misalign=0, state=HOLD, hold counter=0.
- States: HOLD, RUN, HALT.
- HOLD:
  - fetch_valid=0 and PC is frozen.
  - The counter increments each cycle; the state moves to RUN on the cycle the counter reaches RESET_HOLD-1.
  - If RESET_HOLD=0, the state goes directly to RUN on the first non-reset cycle.
  - With the default of 1, the first fetch_valid=1 appears in the second cycle after reset falls.
  - Redirect, trap and halt inputs are ignored in HOLD.
- RUN:
  - fetch_valid=1.
  - Next-PC priority: trap_valid > redirect_valid > handshake (fetch_valid&&fetch_ready) > hold.
  - Trap: fetch_pc<=trap_vector; epoch<=epoch+1 (mod 2^EPOCH_W).
  - Redirect: fetch_pc<=redirect_pc; epoch<=epoch+1.
  - Handshake: fetch_pc<=fetch_pc+INSTR_BYTES, truncated mod 2^XLEN, so 0xFFFF_FFFC wraps to 0. Epoch is unchanged.
  - While fetch_valid&&!fetch_ready and there is no redirect or trap, fetch_pc and fetch_epoch stay stable.
  - A redirect or trap may replace an unaccepted request; the dropped address is never re-issued.
- halt_req in RUN:
  - The next-PC update of that cycle still applies, then the state moves to HALT.
  - fetch_valid=0 and halted=1 from the next cycle.
- HALT:
  - fetch_valid=0.
  - Trap or redirect updates fetch_pc and epoch while remaining in HALT.
  - resume moves the state to RUN on the next cycle; resume has priority over a simultaneous halt_req.
- Latency: every redirect, trap or increment is visible on fetch_pc one cycle after the sampling edge.
- Epoch counter wraps from 2^EPOCH_W-1 to 0.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect_pc with any of bits [log2(INSTR_BYTES)-1:0] nonzero is not taken.
  - Instead fetch_pc<=trap_vector, epoch increments, and misalign pulses for 1 cycle.
  - A simultaneous trap_valid keeps priority, and misalign stays 0 in that case.
- Undefined: the low bits of redirect_pc are forced to 0 before loading, and misalign is constant 0.

Decomposition:
- Package pc_seq_pkg holds:
  - pc_state_t enum {HOLD, RUN, HALT};
  - localparam helpers: PC_ALIGN_BITS=$clog2(INSTR_BYTES), HOLD_CNT_W=4.
- Sub-module pc_hold_timer: a 4-bit reset-hold counter with a done output, instantiated once.

Test Plan:
- Reset with defaults, fetch_ready=1 → cycle 1 after reset falls: fetch_valid=0, fetch_pc=0. Cycle 2: valid=1, pc=0. Then pc=4, 8, 12 on consecutive cycles.
- fetch_ready=0 for 3 cycles at pc=0x10 → pc stays 0x10 and epoch stays constant. Ready returns → next pc=0x14.
- redirect_valid and trap_valid in the same cycle (redirect_pc=0x200, trap_vector=0x80), epoch=3 with EPOCH_W=2 → pc=0x80, epoch=0.
- halt_req with a concurrent handshake at pc=0x40 → next cycle pc=0x44, halted=1, fetch_valid=0. resume → valid=1 at 0x44 the following cycle.
- RESET_HOLD=3; reset asserted mid-stream at pc=0x1000 → pc=RESET_VECTOR, valid=0 for 3 cycles after release.
- With PC_MISALIGN_TRAP_EN, redirect_pc=0x102, trap_vector=0x80 → pc=0x80, misalign=1 for one cycle. Without the macro → pc=0x100, misalign=0.
